// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - branch/jump resolve, redirect and link sequencing for the ID stage
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid                 ID stage holds a valid instruction
//   br_type[2:0]             0=NONE 1=BEQ 2=BNE 3=J 4=JAL 5=JR (6,7 = NONE)
//   id_pc_4[31:0]            PC+4 of the instruction in ID
//   id_offset[15:0]          branch immediate (word offset)
//   id_index[25:0]           jump index
//   rs_val, rt_val[31:0]     forwarded operands, valid when opnd_ready=1
//   opnd_ready               operands valid this cycle
//   stall_id                 hold PC and IF/ID (combinational)
//   pc_redirect, flush_if    one-cycle redirect/squash pulse (registered)
//   redir_target[31:0]       redirect address, holds between redirects
//   link_we, link_addr[31:0] $31 write for a taken JAL, aligned with pc_redirect
//   taken_cnt[15:0]          wrapping count of redirects issued
//   hazard_to                sticky flag: operands not ready after 7 WAIT cycles

module branch_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  br_type,
  input  logic [31:0] id_pc_4,
  input  logic [15:0] id_offset,
  input  logic [25:0] id_index,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        opnd_ready,
  output logic        stall_id,
  output logic        pc_redirect,
  output logic [31:0] redir_target,
  output logic        flush_if,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic [15:0] taken_cnt,
  output logic        hazard_to
);

  localparam logic [2:0] BR_BEQ = 3'd1;
  localparam logic [2:0] BR_BNE = 3'd2;
  localparam logic [2:0] BR_J   = 3'd3;
  localparam logic [2:0] BR_JAL = 3'd4;
  localparam logic [2:0] BR_JR  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  wait_cnt, wait_cnt_nxt;

  logic        is_br;
  logic        is_dep;
  logic        is_jal;
  logic        active;
  logic        taken;
  logic [31:0] target;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_WAIT: begin
        if (stall_id) begin
          state_nxt = S_WAIT;
        end else if (taken) begin
          state_nxt = S_REDIR;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REDIR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / resolve logic
  always_comb begin
    is_br  = (br_type >= BR_BEQ) && (br_type <= BR_JR);
    is_dep = (br_type == BR_BEQ) || (br_type == BR_BNE) || (br_type == BR_JR);
    is_jal = (br_type == BR_JAL);
    // REDIR ignores the ID stage entirely; the instruction there is being squashed.
    active = (state != S_REDIR) && id_valid && is_br;
    stall_id = active && is_dep && !opnd_ready;

    taken = 1'b0;
    if (active && (!is_dep || opnd_ready)) begin
      case (br_type)
        BR_BEQ:              taken = (rs_val == rt_val);
        BR_BNE:              taken = (rs_val != rt_val);
        BR_J, BR_JAL, BR_JR: taken = 1'b1;
        default:             taken = 1'b0;
      endcase
    end

    case (br_type)
      BR_BEQ, BR_BNE: target = id_pc_4 + {{14{id_offset[15]}}, id_offset, 2'b00};
      BR_J, BR_JAL:   target = {id_pc_4[31:28], id_index, 2'b00};
      default:        target = rs_val;
    endcase
  end

  // Wait counter: entering WAIT loads 1, so the count equals WAIT cycles spent so far.
  always_comb begin
    wait_cnt_nxt = 3'd0;
    if (state_nxt == S_WAIT) begin
      if (state != S_WAIT) begin
        wait_cnt_nxt = 3'd1;
      end else if (wait_cnt == 3'd7) begin
        wait_cnt_nxt = 3'd7;
      end else begin
        wait_cnt_nxt = wait_cnt + 3'd1;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_redirect  <= 1'b0;
      flush_if     <= 1'b0;
      link_we      <= 1'b0;
      redir_target <= 32'd0;
      link_addr    <= 32'd0;
      taken_cnt    <= 16'd0;
      hazard_to    <= 1'b0;
      wait_cnt     <= 3'd0;
    end else begin
      pc_redirect <= taken;
      flush_if    <= taken;
      link_we     <= taken && is_jal;
      wait_cnt    <= wait_cnt_nxt;
      if (taken) begin
        redir_target <= target;
        taken_cnt    <= taken_cnt + 16'd1;
      end
      if (taken && is_jal) begin
        link_addr <= id_pc_4;
      end
      if ((state == S_WAIT) && stall_id && (wait_cnt == 3'd7)) begin
        hazard_to <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer

module tb_branch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [2:0]  br_type;
  logic [31:0] id_pc_4;
  logic [15:0] id_offset;
  logic [25:0] id_index;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        opnd_ready;
  logic        stall_id;
  logic        pc_redirect;
  logic [31:0] redir_target;
  logic        flush_if;
  logic        link_we;
  logic [31:0] link_addr;
  logic [15:0] taken_cnt;
  logic        hazard_to;

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .br_type(br_type),
    .id_pc_4(id_pc_4), .id_offset(id_offset), .id_index(id_index),
    .rs_val(rs_val), .rt_val(rt_val), .opnd_ready(opnd_ready),
    .stall_id(stall_id), .pc_redirect(pc_redirect), .redir_target(redir_target),
    .flush_if(flush_if), .link_we(link_we), .link_addr(link_addr),
    .taken_cnt(taken_cnt), .hazard_to(hazard_to)
  );

  typedef struct {
    logic [31:0] target;
    logic        lw;
    logic [31:0] la;
    logic [15:0] cnt;
  } redir_t;

  redir_t exp_q[$];
  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] pc4, input logic [15:0] off,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rdy);
    id_valid = 1'b1; br_type = t; id_pc_4 = pc4; id_offset = off;
    id_index = idx; rs_val = rs; rt_val = rt; opnd_ready = rdy;
  endtask

  task automatic idle_in();
    id_valid = 1'b0; br_type = 3'd0; opnd_ready = 1'b0;
  endtask

  task automatic push(input logic [31:0] tgt, input logic lw, input logic [31:0] la,
                      input logic [15:0] cnt);
    redir_t r;
    r.target = tgt; r.lw = lw; r.la = la; r.cnt = cnt;
    exp_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_redirect"}, {31'd0, pc_redirect}, 32'd0);
    chk({tag, "_flush_if"}, {31'd0, flush_if}, 32'd0);
    chk({tag, "_link_we"}, {31'd0, link_we}, 32'd0);
    chk({tag, "_redir_target"}, redir_target, 32'd0);
    chk({tag, "_link_addr"}, link_addr, 32'd0);
    chk({tag, "_taken_cnt"}, {16'd0, taken_cnt}, 32'd0);
    chk({tag, "_hazard_to"}, {31'd0, hazard_to}, 32'd0);
    chk({tag, "_stall_id"}, {31'd0, stall_id}, 32'd0);
  endtask

  // Monitor: every redirect pulse must match the head of the expected queue.
  initial begin
    redir_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pc_redirect) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_redirect got pc_redirect=1 target=0x%08h expected no redirect",
                     redir_target);
          end else begin
            r = exp_q.pop_front();
            chk("redir_target", redir_target, r.target);
            chk("redir_taken_cnt", {16'd0, taken_cnt}, {16'd0, r.cnt});
            chk("redir_flush_if", {31'd0, flush_if}, 32'd1);
            chk("redir_link_we", {31'd0, link_we}, {31'd0, r.lw});
            if (r.lw) chk("redir_link_addr", link_addr, r.la);
          end
        end else if (flush_if || link_we) begin
          checks++;
          errors++;
          $display("FAIL stray_pulse got flush_if=%0b link_we=%0b expected 0 0", flush_if, link_we);
        end
      end
    end
  end

  initial begin
    logic [15:0] exp_cnt;
    rst_n = 1'b0;
    id_valid = 1'b0; br_type = 3'd0; id_pc_4 = 32'd0; id_offset = 16'd0;
    id_index = 26'd0; rs_val = 32'd0; rt_val = 32'd0; opnd_ready = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // BEQ taken, backward offset, resolves on first edge after release
    drive(3'd1, 32'h0040_0010, 16'hFFFC, 26'd0, 32'd5, 32'd5, 1'b1);
    #1 chk("beq_stall", {31'd0, stall_id}, 32'd0);
    push(32'h0040_0000, 1'b0, 32'd0, 16'd1);
    tick(); idle_in();
    tick();

    // BNE not taken: no redirect, count unchanged, still in IDLE
    drive(3'd2, 32'h0040_0020, 16'h0010, 26'd0, 32'd7, 32'd7, 1'b1);
    tick();
    chk("bne_pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("bne_taken_cnt", {16'd0, taken_cnt}, 32'd1);

    // JAL immediately after (proves IDLE): link pulse for one cycle
    drive(3'd4, 32'h1000_0004, 16'd0, 26'h000_0100, 32'd0, 32'd0, 1'b0);
    push(32'h1000_0400, 1'b1, 32'h1000_0004, 16'd2);
    tick(); idle_in();
    tick();
    chk("jal_link_we_after", {31'd0, link_we}, 32'd0);
    chk("jal_link_addr_hold", link_addr, 32'h1000_0004);
    chk("jal_target_hold", redir_target, 32'h1000_0400);

    // JR with 3 cycles of operand wait
    drive(3'd5, 32'h0000_1000, 16'd0, 26'd0, 32'h0000_0080, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("jr_stall", {31'd0, stall_id}, 32'd1);
      tick();
    end
    opnd_ready = 1'b1;
    #1 chk("jr_stall_ready", {31'd0, stall_id}, 32'd0);
    push(32'h0000_0080, 1'b0, 32'd0, 16'd3);
    tick(); idle_in();
    #1 chk("redir_stall", {31'd0, stall_id}, 32'd0);
    tick();

    // BEQ with 8 cycles of operand wait: timeout flag
    drive(3'd1, 32'h0000_0100, 16'h0004, 26'd0, 32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("hazard_before", {31'd0, hazard_to}, 32'd0);
    tick();
    chk("hazard_set", {31'd0, hazard_to}, 32'd1);
    chk("hazard_stall", {31'd0, stall_id}, 32'd1);
    opnd_ready = 1'b1;
    push(32'h0000_0110, 1'b0, 32'd0, 16'd4);
    tick(); idle_in();
    tick(); tick();
    chk("hazard_sticky", {31'd0, hazard_to}, 32'd1);

    // id_valid drops in WAIT: back to IDLE, no redirect
    drive(3'd2, 32'h0000_0200, 16'h0004, 26'd0, 32'd1, 32'd2, 1'b0);
    tick(); tick();
    idle_in();
    #1 chk("drop_stall", {31'd0, stall_id}, 32'd0);
    tick(); tick();
    chk("drop_taken_cnt", {16'd0, taken_cnt}, 32'd4);

    // Reset during REDIR cancels the pulse
    drive(3'd4, 32'h3000_0008, 16'd0, 26'h000_0010, 32'd0, 32'd0, 1'b0);
    tick(); idle_in();
    chk("redir_before_reset", {31'd0, pc_redirect}, 32'd1);
    chk("link_before_reset", {31'd0, link_we}, 32'd1);
    rst_n = 1'b0;
    #1 chk_all_zero("redir_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_reset_pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("post_reset_taken_cnt", {16'd0, taken_cnt}, 32'd0);

    // Counter wrap: 65535 taken J, then one more
    exp_cnt = 16'd0;
    for (int i = 0; i < 65536; i++) begin
      drive(3'd3, 32'h2000_0000, 16'd0, 26'(i), 32'd0, 32'd0, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      push({4'h2, 26'(i), 2'b00}, 1'b0, 32'd0, exp_cnt);
      tick(); idle_in();
      if (i == 65534) begin
        #1 chk("cnt_ffff", {16'd0, taken_cnt}, 32'h0000_FFFF);
      end
      tick();
    end
    chk("cnt_wrap", {16'd0, taken_cnt}, 32'd0);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
